risc_sequencer: RTL and testbench
=================================

Name: risc_sequencer

Overview:
- Phase sequencer and control-signal generator for the VeryRISC CPU core, sitting between the instruction register/accumulator and the PC, memory, ALU and accumulator load enables.
- Runs the fixed 8-phase instruction cycle and decodes the 3-bit opcode into per-phase control strobes.
- Adds run/single-step control and a retired-instruction counter for debug.

Parameters:
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- opcode  input  3  IR[7:5]: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
- zero  input  1  accumulator-is-zero flag
- run  input  1  1 = free-run; 0 = pause at next instruction boundary
- step  input  1  while paused, 1 for one clock executes exactly one instruction
- sel  output  1  address mux: 1 = PC, 0 = IR operand
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC increment
- ld_pc  output  1  PC load (jump)
- data_e  output  1  accumulator drives data bus
- ld_ac  output  1  accumulator load
- wr  output  1  memory write
- halt  output  1  CPU halted
- paused  output  1  sequencer idle at boundary
- phase  output  3  current phase 0..7
- retired  output  CNT_W  count of completed instructions

Behaviour:
- State: phase[2:0], paused, halted, retired.
  - Reset (async): phase=0, paused=0, halted=0, retired=0.
  - All control outputs 0 during reset, except sel=1 (phase 0 decode).
- ALUOP = opcode in {ADD, AND, XOR, LDA}.
- Controls are combinational from registered state plus opcode/zero. All are 0 when paused=1.
  - Ph0 INST_ADDR: sel.
  - Ph1 INST_FETCH: sel, rd.
  - Ph2 INST_LOAD: sel, rd, ld_ir.
  - Ph3 IDLE: sel, rd, ld_ir.
  - Ph4 OP_ADDR: if HLT then halt=1, inc_pc=0; else inc_pc=1.
  - Ph5 OP_FETCH: rd=ALUOP.
  - Ph6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO.
  - Ph7 STORE: rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO.
- Phase advance: phase+1 each clock, wrapping 7 -> 0, unless halted or paused.
- Halt:
  - Edge in phase 4 with opcode HLT sets halted=1.
  - Once halted, phase holds at 4 and halt stays 1 until reset.
  - No other strobes assert while halted; run and step are ignored.
  - The HLT instruction is not counted in retired.
- Retire: on the phase 7 -> 0 edge, retired increments by 1, wrapping modulo 2^CNT_W.
- Pause:
  - On the phase 7 -> 0 edge, paused <= ~run.
  - While paused, phase holds at 0.
  - Leave pause on the next edge if run=1 or step=1; run and step together behave as run.
  - After a step, run=0 re-pauses at the following boundary, giving exactly one instruction.
  - Deasserting run mid-instruction has no effect until phase 7 completes.
- Latency: after reset deassert, edge N moves phase from N-1 to N. A HLT at PC 0 drives halt=1 after the 4th edge.
- Reset mid-instruction or while halted: immediate return to phase 0, halted=0, paused=0, retired=0.

Test Plan:
- opcode=HLT held, run=1, reset -> halt=0 after edges 1-3; halt=1 and phase=4 after edge 4; holds 20 more clocks; retired=0; inc_pc never 1.
- opcode=JMP, run=1 -> ld_pc=1 in phases 6 and 7 only; retired=1 after edge 8; phase=0.
- opcode=SKZ: with zero=1, inc_pc=1 in phase 4 and phase 6; with zero=0, inc_pc=1 only in phase 4.
- opcode=STO -> data_e=1 in phases 6 and 7, wr=1 in phase 7 only. opcode=ADD -> rd=1 in phases 5-7, ld_ac=1 in phase 7.
- run=0 from reset, opcode=LDA -> paused=1 after edge 8, all strobes 0 and phase=0 for 10 clocks. One-clock step pulse -> one instruction, retired=2, paused again. run=1 -> continuous execution resumes.
- CNT_W=2, opcode=ADD free-run 4 instructions -> retired wraps 3 -> 0. Async rst asserted in phase 5 -> all state cleared without waiting for a clock edge.

Source files
------------

// File: rtl/risc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : risc_sequencer
// Purpose  : 8-phase instruction-cycle sequencer and control-strobe decoder for
//            the VeryRISC core, with run/single-step control and retire counter.
// Revision : 1.0 - initial release
//==============================================================================
module risc_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             run,
  input  logic             step,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic             halt,
  output logic             paused,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  phase_t           r_phase;
  logic             r_paused;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;

  phase_t           w_phase_nxt;
  logic             w_paused_nxt;
  logic             w_halted_nxt;
  logic             w_retire;
  logic [2:0]       w_phase_inc;
  logic             w_aluop;
  logic             w_is_hlt;
  logic             w_is_sto;
  logic             w_is_jmp;

  assign w_phase_inc = r_phase + 3'd1;
  assign w_aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
  assign w_is_hlt = (opcode == OP_HLT);
  assign w_is_sto = (opcode == OP_STO);
  assign w_is_jmp = (opcode == OP_JMP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase   <= PH_INST_ADDR;
      r_paused  <= 1'b0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_paused <= w_paused_nxt;
      r_halted <= w_halted_nxt;
      if (w_retire)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_paused_nxt = r_paused;
    w_halted_nxt = r_halted;
    w_retire     = 1'b0;
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    halt   = 1'b0;

    if (r_halted) begin
      halt = 1'b1;
    end else if (r_paused) begin
      // Idle at the boundary; either request releases without advancing phase.
      if (run || step)
        w_paused_nxt = 1'b0;
    end else begin
      w_phase_nxt = phase_t'(w_phase_inc);
      case (r_phase)
        PH_INST_ADDR:  sel = 1'b1;
        PH_INST_FETCH: begin sel = 1'b1; rd = 1'b1; end
        PH_INST_LOAD,
        PH_IDLE:       begin sel = 1'b1; rd = 1'b1; ld_ir = 1'b1; end
        PH_OP_ADDR: begin
          if (w_is_hlt) begin
            halt         = 1'b1;
            w_halted_nxt = 1'b1;
            w_phase_nxt  = r_phase;
          end else begin
            inc_pc = 1'b1;
          end
        end
        PH_OP_FETCH:   rd = w_aluop;
        PH_ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = w_is_jmp;
          data_e = w_is_sto;
        end
        PH_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop;
          ld_pc  = w_is_jmp;
          data_e = w_is_sto;
          wr     = w_is_sto;
          w_retire     = 1'b1;
          w_paused_nxt = ~run;
        end
      endcase
    end
  end

  assign phase   = r_phase;
  assign paused  = r_paused;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_risc_sequencer.sv
`default_nettype none
//==============================================================================
// Module   : tb_risc_sequencer
// Purpose  : Directed scoreboard bench for risc_sequencer (default and 2-bit
//            retire counter instances driven in lockstep).
// Revision : 1.0 - initial release
//==============================================================================
module tb_risc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       run = 1'b1;
  logic       step = 1'b0;

  logic sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, paused;
  logic [2:0]  phase;
  logic [15:0] retired;
  logic sel2, rd2, ld_ir2, inc_pc2, ld_pc2, data_e2, ld_ac2, wr2, halt2, paused2;
  logic [2:0]  phase2;
  logic [1:0]  retired2;

  int n_checks = 0;
  int n_errors = 0;

  risc_sequencer #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .run(run), .step(step),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .data_e(data_e), .ld_ac(ld_ac), .wr(wr), .halt(halt), .paused(paused),
    .phase(phase), .retired(retired)
  );

  risc_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .run(run), .step(step),
    .sel(sel2), .rd(rd2), .ld_ir(ld_ir2), .inc_pc(inc_pc2), .ld_pc(ld_pc2),
    .data_e(data_e2), .ld_ac(ld_ac2), .wr(wr2), .halt(halt2), .paused(paused2),
    .phase(phase2), .retired(retired2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [9:0]  ctl;   // {sel,rd,ld_ir,inc_pc,ld_pc,data_e,ld_ac,wr,halt,paused}
    logic [2:0]  ph;
    logic [15:0] ret;
  } exp_t;

  exp_t sb[$];

  // Reference state of the instruction-cycle model.
  int          m_phase;
  bit          m_paused;
  bit          m_halted;
  logic [15:0] m_retired;

  function automatic logic [9:0] model_ctl();
    logic s, r, li, ip, lp, de, la, w, h;
    bit alu;
    alu = (opcode == 3'd2) || (opcode == 3'd3) || (opcode == 3'd4) || (opcode == 3'd5);
    {s, r, li, ip, lp, de, la, w, h} = '0;
    if (m_halted) h = 1'b1;
    else if (!m_paused) begin
      case (m_phase)
        0: s = 1;
        1: begin s = 1; r = 1; end
        2, 3: begin s = 1; r = 1; li = 1; end
        4: if (opcode == 3'd0) h = 1; else ip = 1;
        5: r = alu;
        6: begin r = alu; ip = (opcode == 3'd1) && zero; lp = (opcode == 3'd7); de = (opcode == 3'd6); end
        default: begin r = alu; la = alu; lp = (opcode == 3'd7); de = (opcode == 3'd6); w = (opcode == 3'd6); end
      endcase
    end
    return {s, r, li, ip, lp, de, la, w, h, m_paused};
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.ctl = model_ctl();
    e.ph  = 3'(m_phase);
    e.ret = m_retired;
    sb.push_back(e);
  endfunction

  function automatic void model_reset();
    m_phase = 0; m_paused = 0; m_halted = 0; m_retired = '0;
  endfunction

  function automatic void model_edge();
    if (m_halted) return;
    if (m_paused) begin
      if (run || step) m_paused = 0;
    end else if (m_phase == 4 && opcode == 3'd0) begin
      m_halted = 1;
    end else if (m_phase == 7) begin
      m_phase = 0;
      m_retired = m_retired + 16'd1;
      m_paused = !run;
    end else begin
      m_phase = m_phase + 1;
    end
  endfunction

  task automatic check_out(input string tag);
    exp_t e;
    logic [9:0] obs;
    logic [1:0] exp_r2;
    if (sb.size() == 0) begin
      n_checks++; n_errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    exp_r2 = e.ret[1:0];
    obs = {sel, rd, ld_ir, inc_pc, ld_pc, data_e, ld_ac, wr, halt, paused};
    n_checks++;
    assert (obs === e.ctl) else begin
      n_errors++;
      $error("FAIL %s ctl: observed %b expected %b (phase %0d)", tag, obs, e.ctl, e.ph);
    end
    n_checks++;
    assert (phase === e.ph) else begin
      n_errors++;
      $error("FAIL %s phase: observed %0d expected %0d", tag, phase, e.ph);
    end
    n_checks++;
    assert (retired === e.ret) else begin
      n_errors++;
      $error("FAIL %s retired: observed %0d expected %0d", tag, retired, e.ret);
    end
    n_checks++;
    assert (retired2 === exp_r2) else begin
      n_errors++;
      $error("FAIL %s retired2: observed %0d expected %0d", tag, retired2, exp_r2);
    end
  endtask

  task automatic cycles(input int n, input string tag);
    repeat (n) begin
      model_edge();
      push_exp();
      @(posedge clk);
      #1;
      check_out(tag);
    end
  endtask

  // Asynchronous reset applied away from any clock edge; checked before the next edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    check_out(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    opcode = 3'd0; run = 1'b1;
    do_reset("reset_state");
    cycles(24, "hlt");

    opcode = 3'd7;
    do_reset("reset_jmp");
    cycles(10, "jmp");

    opcode = 3'd1; zero = 1'b1;
    do_reset("reset_skz");
    cycles(8, "skz_z1");
    zero = 1'b0;
    cycles(8, "skz_z0");

    opcode = 3'd6;
    cycles(8, "sto");
    opcode = 3'd2;
    cycles(8, "add");

    opcode = 3'd5; run = 1'b0;
    do_reset("reset_pause");
    cycles(8, "lda_to_pause");
    cycles(10, "paused_hold");
    step = 1'b1;
    cycles(1, "step_pulse");
    step = 1'b0;
    cycles(8, "step_instr");
    cycles(3, "repaused");
    run = 1'b1;
    cycles(17, "resume");

    opcode = 3'd2;
    do_reset("reset_wrap");
    cycles(32, "add_wrap");
    cycles(5, "to_phase5");
    #2;
    do_reset("async_reset_ph5");
    cycles(3, "after_reset");

    if (sb.size() != 0) begin
      n_checks++; n_errors++;
      $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
